// File: rtl/csa_accum_ctrl_if.sv
// Job, operand-beat and result signals of the carry-save accumulation controller.
// master = job/operand source and result sink; slave = the controller.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int OPS_W = 8,
    parameter int ACC_W = 24
);
    // Both handshakes are strict valid/ready: a transfer happens on a rising
    // edge where valid and ready are both high. The source holds its payload
    // stable until that edge. abort overrides every transfer in its cycle.
    logic             start;
    logic [OPS_W-1:0] num_ops;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    modport master (
        output start, num_ops, abort, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, num_ops, abort, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand unsigned accumulator: two operands per beat are folded into a
// registered (sum, carry) pair by one row of 4:2 compressors, then resolved once.
module csa_accum_ctrl #(
    parameter int WIDTH = 16,
    parameter int OPS_W = 8,
    parameter int ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csa_accum_ctrl_if.slave       bus,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_sum;
    logic [ACC_W-1:0]   r_carry;
    logic [OPS_W-1:0]   r_remaining;
    logic [ACC_W-1:0]   r_out_sum;

    logic [ACC_W-1:0]   w_op_a;
    logic [ACC_W-1:0]   w_op_b;
    logic [ACC_W-1:0]   w_s1;
    logic [ACC_W-2:0]   w_cout;
    logic [ACC_W-1:0]   w_cin;
    logic [ACC_W-1:0]   w_row_sum;
    logic [ACC_W-2:0]   w_row_carry;
    logic               w_last_beat;
    logic [OPS_W-1:0]   w_rem_next;
    logic               w_beat;

    // The first full adder of each 4:2 cell only sees sum, carry and op_a, so
    // the lateral cout chain is one level deep and never ripples.
    always_comb begin
        w_op_a      = ACC_W'(bus.in_a);
        w_op_b      = (r_remaining == OPS_W'(1)) ? '0 : ACC_W'(bus.in_b);
        w_s1        = r_sum ^ r_carry ^ w_op_a;
        w_cout      = (r_sum[ACC_W-2:0] & r_carry[ACC_W-2:0])
                    | (r_sum[ACC_W-2:0] & w_op_a[ACC_W-2:0])
                    | (r_carry[ACC_W-2:0] & w_op_a[ACC_W-2:0]);
        w_cin       = {w_cout, 1'b0};
        w_row_sum   = w_s1 ^ w_op_b ^ w_cin;
        w_row_carry = (w_s1[ACC_W-2:0] & w_op_b[ACC_W-2:0])
                    | (w_s1[ACC_W-2:0] & w_cin[ACC_W-2:0])
                    | (w_op_b[ACC_W-2:0] & w_cin[ACC_W-2:0]);
    end

    assign w_last_beat = (r_remaining <= OPS_W'(2));
    assign w_rem_next  = w_last_beat ? '0 : (r_remaining - OPS_W'(2));
    assign w_beat      = (r_state == ACCUM) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_next = (bus.num_ops == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid && w_last_beat) begin
                        w_state_next = RESOLVE;
                    end
                end
                RESOLVE: begin
                    w_state_next = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // out_sum deliberately survives abort so the last delivered result stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_remaining <= '0;
            r_out_sum   <= '0;
        end else if (bus.abort) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_remaining <= '0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_sum       <= '0;
                r_carry     <= '0;
                r_remaining <= bus.num_ops;
                if (bus.num_ops == '0) begin
                    r_out_sum <= '0;
                end
            end
            if (w_beat) begin
                r_sum       <= w_row_sum;
                r_carry     <= {w_row_carry, 1'b0};
                r_remaining <= w_rem_next;
            end
            if (r_state == RESOLVE) begin
                r_out_sum <= r_sum + r_carry;
            end
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_sum   = r_out_sum;
    assign o_state       = r_state;

endmodule
